jtkcpu_shd_seq: RTL and testbench

JTKCPU_SHD_SEQ -- requirements
Module: jtkcpu_shd_seq

---
 rtl/jtkcpu_shd_seq.sv | 127 ++++++++++++
 tb/tb_jtkcpu_shd_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtkcpu_shd_seq.sv
// Multi-cycle D-register shift sequencer: repeats a one-bit ALU step `cnt` times.
// Optional macro JTKCPU_SHD_SAT_EN clamps ASR/LSR/ASL counts above 16 down to 16.
module jtkcpu_shd_seq (
    input  logic        rst,
    input  logic        clk,
    input  logic        cen,
    input  logic        start,
    input  logic [2:0]  kind,
    input  logic [7:0]  cnt,
    input  logic [15:0] d_in,
    input  logic [7:0]  cc_in,
    input  logic [15:0] step_rslt,
    input  logic [7:0]  step_cc,
    output logic        step_en,
    output logic [2:0]  step_op,
    output logic [15:0] step_opnd,
    output logic [7:0]  step_cci,
    output logic        busy,
    output logic        done,
    output logic [15:0] d_out,
    output logic [7:0]  cc_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [15:0] acc;
    logic [7:0]  ccr;
    logic [2:0]  op;
    logic [7:0]  rem;
    logic        bypass;
    logic        last_step;
    logic [7:0]  start_rem;

    // Zero counts and unknown kinds skip RUN and report the inputs unchanged.
    always_comb begin
        bypass    = (cnt == 8'd0) || (kind >= 3'd5);
        last_step = (rem <= 8'd1);
`ifdef JTKCPU_SHD_SAT_EN
        start_rem = ((kind <= 3'd2) && (cnt > 8'd16)) ? 8'd16 : cnt;
`else
        start_rem = cnt;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (cen) begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = bypass ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: the final step result is captured into d_out/cc_out as RUN exits,
    // so the published result stays stable until the next accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= 16'd0;
            ccr    <= 8'd0;
            op     <= 3'd0;
            rem    <= 8'd0;
            d_out  <= 16'd0;
            cc_out <= 8'd0;
        end else if (cen) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= d_in;
                        ccr <= cc_in;
                        op  <= kind;
                        rem <= start_rem;
                        if (bypass) begin
                            d_out  <= d_in;
                            cc_out <= cc_in;
                        end
                    end
                end
                RUN: begin
                    acc <= step_rslt;
                    ccr <= step_cc;
                    if (rem != 8'd0) begin
                        rem <= rem - 8'd1;
                    end
                    if (last_step) begin
                        d_out  <= step_rslt;
                        cc_out <= step_cc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        step_en   = (state == RUN);
        step_op   = op;
        step_opnd = acc;
        step_cci  = ccr;
        busy      = (state != IDLE);
        done      = (state == DONE);
    end

endmodule

// File: tb/tb_jtkcpu_shd_seq.sv
// Directed bench for jtkcpu_shd_seq; a behavioural one-bit ALU answers each step.
// Expected latency of the saturated ASR case follows JTKCPU_SHD_SAT_EN.
module tb_jtkcpu_shd_seq;

    logic        rst;
    logic        clk;
    logic        cen;
    logic        start;
    logic [2:0]  kind;
    logic [7:0]  cnt;
    logic [15:0] d_in;
    logic [7:0]  cc_in;
    logic [15:0] step_rslt;
    logic [7:0]  step_cc;
    logic        step_en;
    logic [2:0]  step_op;
    logic [15:0] step_opnd;
    logic [7:0]  step_cci;
    logic        busy;
    logic        done;
    logic [15:0] d_out;
    logic [7:0]  cc_out;

    int total = 0;
    int bad   = 0;

    jtkcpu_shd_seq dut (
        .rst       (rst),
        .clk       (clk),
        .cen       (cen),
        .start     (start),
        .kind      (kind),
        .cnt       (cnt),
        .d_in      (d_in),
        .cc_in     (cc_in),
        .step_rslt (step_rslt),
        .step_cc   (step_cc),
        .step_en   (step_en),
        .step_op   (step_op),
        .step_opnd (step_opnd),
        .step_cci  (step_cci),
        .busy      (busy),
        .done      (done),
        .d_out     (d_out),
        .cc_out    (cc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-bit shift ALU; rotates go through the carry in CC bit 0.
    logic [15:0] alu_r;
    logic        alu_c;
    always_comb begin
        alu_r = step_opnd;
        alu_c = step_cci[0];
        case (step_op)
            3'd0: begin alu_r = {step_opnd[15], step_opnd[15:1]}; alu_c = step_opnd[0]; end
            3'd1: begin alu_r = {1'b0, step_opnd[15:1]};          alu_c = step_opnd[0]; end
            3'd2: begin alu_r = {step_opnd[14:0], 1'b0};          alu_c = step_opnd[15]; end
            3'd3: begin alu_r = {step_cci[0], step_opnd[15:1]};   alu_c = step_opnd[0]; end
            3'd4: begin alu_r = {step_opnd[14:0], step_cci[0]};   alu_c = step_opnd[15]; end
            default: begin end
        endcase
        step_rslt = alu_r;
        step_cc   = {step_cci[7:1], alu_c};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [2:0] k, input logic [7:0] n,
                          input logic [15:0] d, input logic [7:0] c);
        kind  = k;
        cnt   = n;
        d_in  = d;
        cc_in = c;
        start = 1'b1;
        cen   = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Counts cycles from the accepting edge until done shows, bounded by limit.
    task automatic wait_done(input int limit, output int cycles,
                             output int busy_cycles, output logic saw_step);
        cycles      = 1;
        busy_cycles = 0;
        saw_step    = 1'b0;
        while (1) begin
            if (busy) busy_cycles++;
            if (step_en) saw_step = 1'b1;
            if (done || cycles >= limit) break;
            tick();
            cycles++;
        end
    endtask

    int   lat;
    int   bcy;
    logic seen;
    int   en_cycles;
    int   guard;
    int   sat_lat;

    initial begin
        rst   = 1'b1;
        cen   = 1'b0;
        start = 1'b0;
        kind  = 3'd0;
        cnt   = 8'd0;
        d_in  = 16'd0;
        cc_in = 8'd0;
        repeat (2) tick();
        check("rst_busy",  32'(busy), 32'h0);
        check("rst_done",  32'(done), 32'h0);
        check("rst_sten",  32'(step_en), 32'h0);
        check("rst_dout",  32'(d_out), 32'h0);
        check("rst_ccout", 32'(cc_out), 32'h0);
        rst = 1'b0;
        cen = 1'b1;
        tick();

        // ASL 0x0001 by 4; also a start held in DONE must be ignored
        launch(3'd2, 8'd4, 16'h0001, 8'h00);
        check("asl_sten",  32'(step_en), 32'h1);
        check("asl_stop",  32'(step_op), 32'h2);
        check("asl_opnd",  32'(step_opnd), 32'h0001);
        wait_done(50, lat, bcy, seen);
        check("asl_lat",   32'(lat), 32'd5);
        check("asl_busy",  32'(bcy), 32'd5);
        check("asl_dout",  32'(d_out), 32'h0010);
        check("asl_ccout", 32'(cc_out), 32'h00);
        start = 1'b1;
        kind  = 3'd6;
        cnt   = 8'd0;
        tick();
        start = 1'b0;
        check("asl_idle_busy", 32'(busy), 32'h0);
        check("asl_idle_done", 32'(done), 32'h0);
        tick();
        check("asl_nostart",   32'(busy), 32'h0);

        // LSR 0x8000 by 15
        launch(3'd1, 8'd15, 16'h8000, 8'hFF);
        wait_done(50, lat, bcy, seen);
        check("lsr_lat",   32'(lat), 32'd16);
        check("lsr_dout",  32'(d_out), 32'h0001);
        check("lsr_ccout", 32'(cc_out), 32'hFE);
        tick();

        // ROR 0x0000 with C=1 by 1
        launch(3'd3, 8'd1, 16'h0000, 8'h01);
        wait_done(50, lat, bcy, seen);
        check("ror_lat",   32'(lat), 32'd2);
        check("ror_dout",  32'(d_out), 32'h8000);
        check("ror_ccout", 32'(cc_out), 32'h00);
        tick();

        // ROL 0x8001 with C=0 by 2
        launch(3'd4, 8'd2, 16'h8001, 8'h00);
        wait_done(50, lat, bcy, seen);
        check("rol_lat",   32'(lat), 32'd3);
        check("rol_dout",  32'(d_out), 32'h0005);
        check("rol_ccout", 32'(cc_out), 32'h00);
        tick();

        // Zero count and invalid kind pass through untouched
        launch(3'd2, 8'd0, 16'h1234, 8'hA5);
        wait_done(50, lat, bcy, seen);
        check("zero_lat",   32'(lat), 32'd1);
        check("zero_dout",  32'(d_out), 32'h1234);
        check("zero_ccout", 32'(cc_out), 32'hA5);
        check("zero_sten",  32'(seen), 32'h0);
        tick();
        launch(3'd6, 8'd5, 16'h1234, 8'hA5);
        wait_done(50, lat, bcy, seen);
        check("inv_lat",   32'(lat), 32'd1);
        check("inv_dout",  32'(d_out), 32'h1234);
        check("inv_ccout", 32'(cc_out), 32'hA5);
        check("inv_sten",  32'(seen), 32'h0);
        tick();

        // ASL by 8 with cen toggling and a stray start mid-run
        launch(3'd2, 8'd8, 16'h0001, 8'h00);
        en_cycles = 1;
        guard     = 0;
        while (!done && guard < 100) begin
            cen = ~cen;
            if (en_cycles == 3 && cen) begin
                start = 1'b1;
                kind  = 3'd3;
                cnt   = 8'd1;
                d_in  = 16'hFFFF;
            end else begin
                start = 1'b0;
            end
            tick();
            guard++;
            if (cen) en_cycles++;
        end
        start = 1'b0;
        check("cen_lat",   32'(en_cycles), 32'd9);
        check("cen_dout",  32'(d_out), 32'h0100);
        check("cen_ccout", 32'(cc_out), 32'h00);
        cen = 1'b0;
        tick();
        check("cen_frz_done", 32'(done), 32'h1);
        check("cen_frz_dout", 32'(d_out), 32'h0100);
        cen = 1'b1;
        tick();
        check("cen_end_done", 32'(done), 32'h0);
        check("cen_end_busy", 32'(busy), 32'h0);

        // Reset mid-run, then a long ASR
        launch(3'd2, 8'd10, 16'h0003, 8'h00);
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_done", 32'(done), 32'h0);
        check("mid_rst_sten", 32'(step_en), 32'h0);
        check("mid_rst_op",   32'(step_op), 32'h0);
        check("mid_rst_opnd", 32'(step_opnd), 32'h0);
        check("mid_rst_cci",  32'(step_cci), 32'h0);
        check("mid_rst_dout", 32'(d_out), 32'h0);
        check("mid_rst_cc",   32'(cc_out), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_idle", 32'(busy), 32'h0);
`ifdef JTKCPU_SHD_SAT_EN
        sat_lat = 17;
`else
        sat_lat = 201;
`endif
        launch(3'd0, 8'd200, 16'h8000, 8'h00);
        wait_done(400, lat, bcy, seen);
        check("asr_lat",   32'(lat), 32'(sat_lat));
        check("asr_dout",  32'(d_out), 32'hFFFF);
        check("asr_ccout", 32'(cc_out), 32'h01);
        tick();
        check("asr_end_busy", 32'(busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
